// File: rtl/vdp99_pkg.sv
// Shared types and constants for the vdp99 VRAM arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vdp99_pkg;

  // Default VRAM address width (16 KiB)
  localparam int DEF_ADDR_W = 14;

  // Width of the data byte carried by a CPU command
  localparam int CMD_DATA_W = 8;

  // Command word layout is {we, addr, wdata}
  localparam int CMD_W = 1 + DEF_ADDR_W + CMD_DATA_W;

  // Arbiter states
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Command word width for an arbitrary address width
  function automatic int cmd_width(input int addr_w);
    return 1 + addr_w + CMD_DATA_W;
  endfunction

endpackage

// File: rtl/vdp99_cmd_fifo.sv
// Synchronous command FIFO with binary pointers carrying an extra wrap bit.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: a push while full is ignored; a pop while empty is ignored.
module vdp99_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 23
) (
  input  logic         pxclk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];
  logic         wr_en;
  logic         rd_en;

  // Same index with opposite wrap bits means every slot is occupied
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rptr[AW-1:0]];

  // Pointer advance; reset flushes all entries
  always_ff @(posedge pxclk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + (AW+1)'(1);
      if (rd_en) rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge pxclk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vdp99_vram_arb.sv
// VRAM arbiter: zero-fill after reset, then display reads win, CPU commands use idle slots.
// Latency: VRAM port is combinational from request/head; read data returns 1 cycle after issue.
// Backpressure: display never stalls; CPU pushes beyond FIFO capacity are dropped and flagged.
module vdp99_vram_arb
  import vdp99_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DEPTH          = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              pxclk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [7:0]        disp_data,
  input  logic              cpu_push,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_full,
  output logic              cpu_busy,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  output logic              ovf,
  output logic [7:0]        wait_max,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_rdata
);

  localparam int CW = cmd_width(ADDR_W);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     head;
  logic [CW-1:0]     cmd_in;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [7:0]        head_wdata;
  logic              pop;
  logic              acc_q;
  logic [7:0]        wcnt;
  logic [7:0]        rdata_hold;

  assign cmd_in     = {cpu_we, cpu_addr, cpu_wdata};
  assign head_we    = head[CW-1];
  assign head_addr  = head[CW-2 -: ADDR_W];
  assign head_wdata = head[7:0];

  vdp99_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .pxclk (pxclk),
    .reset (reset),
    .push  (cpu_push),
    .pop   (pop),
    .din   (cmd_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Next state and VRAM port mux: init walk, then display first, then FIFO head
  always_comb begin
    state_nxt  = state;
    disp_gnt   = 1'b0;
    pop        = 1'b0;
    vram_addr  = last_addr;
    vram_we    = 1'b0;
    vram_wdata = 8'h00;
    case (state)
      ST_INIT: begin
        vram_addr = init_addr;
        vram_we   = 1'b1;
        if (init_addr == '1) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (disp_req) begin
          disp_gnt  = 1'b1;
          vram_addr = disp_addr;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          vram_addr  = head_addr;
          vram_we    = head_we;
          vram_wdata = head_wdata;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // State register and zero-fill address walker
  always_ff @(posedge pxclk) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      init_addr <= '0;
      last_addr <= '0;
    end else begin
      state     <= state_nxt;
      last_addr <= vram_addr;
      if (state == ST_INIT) init_addr <= init_addr + ADDR_W'(1);
    end
  end

  // Read-return pipeline; reset drops any read issued in the reset cycle
  always_ff @(posedge pxclk) begin
    if (reset) begin
      disp_valid <= 1'b0;
      cpu_rvalid <= 1'b0;
      acc_q      <= 1'b0;
      rdata_hold <= 8'h00;
    end else begin
      disp_valid <= disp_gnt;
      cpu_rvalid <= pop && !head_we;
      acc_q      <= pop;
      if (cpu_rvalid) rdata_hold <= vram_rdata;
    end
  end

  // Sticky overflow flag and head wait statistics
  always_ff @(posedge pxclk) begin
    if (reset) begin
      ovf      <= 1'b0;
      wcnt     <= 8'h00;
      wait_max <= 8'h00;
    end else begin
      if (cpu_push && fifo_full) ovf <= 1'b1;
      if (state == ST_RUN && !fifo_empty) begin
        if (pop) begin
          if (wcnt > wait_max) wait_max <= wcnt;
          wcnt <= 8'h00;
        end else if (wcnt != 8'hFF) begin
          wcnt <= wcnt + 8'd1;
        end
      end
    end
  end

  assign disp_data = disp_valid ? vram_rdata : 8'h00;
  assign cpu_rdata = cpu_rvalid ? vram_rdata : rdata_hold;
  assign cpu_full  = fifo_full;
  assign cpu_busy  = (state == ST_INIT) || !fifo_empty || acc_q;

endmodule

// File: tb/tb_vdp99_vram_arb.sv
// Self-checking bench for vdp99_vram_arb with a queue-level reference model.
// Latency: model predicts port mux per cycle and read returns one cycle later.
// Backpressure: model drops pushes when its queue already holds DEPTH entries.
module tb_vdp99_vram_arb;

  localparam int AW    = 14;
  localparam int N     = 1 << AW;
  localparam int DEPTH = 4;

  logic          pxclk = 1'b0;
  logic          reset = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_gnt;
  logic          disp_valid;
  logic [7:0]    disp_data;
  logic          cpu_push = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic          cpu_full;
  logic          cpu_busy;
  logic          cpu_rvalid;
  logic [7:0]    cpu_rdata;
  logic          ovf;
  logic [7:0]    wait_max;
  logic [AW-1:0] vram_addr;
  logic          vram_we;
  logic [7:0]    vram_wdata;
  logic [7:0]    vram_rdata = 8'h00;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 pxclk = ~pxclk;

  vdp99_vram_arb #(
    .ADDR_W         (AW),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .pxclk      (pxclk),
    .reset      (reset),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_gnt   (disp_gnt),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .cpu_push   (cpu_push),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_full   (cpu_full),
    .cpu_busy   (cpu_busy),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ovf        (ovf),
    .wait_max   (wait_max),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // VRAM with one-cycle registered read; first edge preloads 0xFF everywhere
  logic [7:0] vram [N];
  bit mem_ready = 1'b0;
  always @(posedge pxclk) begin
    if (!mem_ready) begin
      for (int i = 0; i < N; i++) vram[i] <= 8'hFF;
      mem_ready <= 1'b1;
    end else begin
      if (vram_we) vram[vram_addr] <= vram_wdata;
      vram_rdata <= vram[vram_addr];
    end
  end

  // Reference model: pending command queue plus expected memory image
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    d;
  } cmd_t;

  initial begin : compare
    cmd_t          q[$];
    cmd_t          c;
    logic [7:0]    ref_mem [N];
    bit            m_on, m_init, m_dv, m_rv, m_prev_pop, m_ovf, full_before;
    int            m_idx, m_wcnt, m_wmax;
    logic [AW-1:0] m_last, e_addr;
    logic [7:0]    m_dd, m_rd, e_wd;
    bit            e_gnt, e_we, e_pop;
    for (int i = 0; i < N; i++) ref_mem[i] = 8'hFF;
    m_on = 0; m_init = 1; m_dv = 0; m_rv = 0; m_prev_pop = 0; m_ovf = 0;
    m_idx = 0; m_wcnt = 0; m_wmax = 0; m_last = '0; m_dd = 0; m_rd = 0;
    forever begin
      @(negedge pxclk);
      if (reset) begin
        q.delete();
        m_on = 1; m_init = 1; m_idx = 0; m_last = '0;
        m_dv = 0; m_rv = 0; m_rd = 8'h00; m_prev_pop = 0;
        m_wcnt = 0; m_wmax = 0; m_ovf = 0;
      end else if (m_on) begin
        e_gnt = 0; e_pop = 0; e_we = 0; e_addr = m_last; e_wd = 8'h00;
        if (m_init) begin
          e_addr = m_idx[AW-1:0];
          e_we   = 1;
        end else if (disp_req) begin
          e_gnt  = 1;
          e_addr = disp_addr;
        end else if (q.size() > 0) begin
          e_pop  = 1;
          e_addr = q[0].addr;
          e_we   = q[0].we;
          e_wd   = q[0].d;
        end
        chk("disp_gnt", disp_gnt, e_gnt);
        chk("vram_we", vram_we, e_we);
        chk("vram_addr", vram_addr, e_addr);
        if (e_we) chk("vram_wdata", vram_wdata, e_wd);
        chk("disp_valid", disp_valid, m_dv);
        if (m_dv) chk("disp_data", disp_data, m_dd);
        chk("cpu_rvalid", cpu_rvalid, m_rv);
        chk("cpu_rdata", cpu_rdata, m_rd);
        chk("cpu_full", cpu_full, q.size() == DEPTH);
        chk("cpu_busy", cpu_busy, m_init || q.size() != 0 || m_prev_pop);
        chk("ovf", ovf, m_ovf);
        chk("wait_max", wait_max, m_wmax);
        // advance model to the next cycle
        m_dv = e_gnt;
        if (e_gnt) m_dd = ref_mem[e_addr];
        m_rv = e_pop && !e_we;
        if (m_rv) m_rd = ref_mem[e_addr];
        m_prev_pop = e_pop;
        if (!m_init && q.size() > 0) begin
          if (e_pop) begin
            if (m_wcnt > m_wmax) m_wmax = m_wcnt;
            m_wcnt = 0;
          end else if (m_wcnt < 255) begin
            m_wcnt++;
          end
        end
        full_before = (q.size() == DEPTH);
        if (e_pop) void'(q.pop_front());
        if (cpu_push) begin
          if (full_before) m_ovf = 1;
          else begin
            c.we = cpu_we; c.addr = cpu_addr; c.d = cpu_wdata;
            q.push_back(c);
          end
        end
        if (e_we) ref_mem[e_addr] = e_wd;
        m_last = e_addr;
        if (m_init) begin
          if (m_idx == N - 1) m_init = 0;
          m_idx++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge pxclk);
    #1;
  endtask

  task automatic push_cmd(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
    cpu_push = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_push = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cnt_ok, cnt_g, cnt_nz, cnt_w, got;
    logic [7:0] rd [8];

    // reset and reset values
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", cpu_busy, 1);
    chk("rst_vram_we", vram_we, 1);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_full", cpu_full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_wait_max", wait_max, 0);
    chk("rst_rdata", cpu_rdata, 0);

    // zero-fill with display requests ignored; one push accepted mid-INIT
    disp_req = 1'b1;
    cnt_ok = 0; cnt_g = 0;
    for (int i = 0; i < N; i++) begin
      disp_addr = AW'(i);
      #1;
      if (vram_we && vram_addr == AW'(i) && vram_wdata == 8'h00) cnt_ok++;
      if (disp_gnt) cnt_g++;
      if (i == 100) begin
        cpu_push = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_wdata = 8'h77;
      end else begin
        cpu_push = 1'b0;
      end
      tick();
    end
    cpu_push = 1'b0;
    chk("init_writes", cnt_ok, N);
    chk("init_gnt", cnt_g, 0);
    disp_req = 1'b0;
    #1;
    chk("init_push_we", vram_we, 1);
    chk("init_push_addr", vram_addr, 14'h0100);
    tick();
    cnt_nz = 0;
    for (int i = 0; i < N; i++) if (i != 14'h0100 && vram[i] != 8'h00) cnt_nz++;
    chk("zero_fill", cnt_nz, 0);
    chk("init_push_data", vram[14'h0100], 8'h77);

    // display priority holds off a queued CPU write
    disp_req = 1'b1; disp_addr = 14'h0800;
    push_cmd(1'b1, 14'h0C00, 8'h5A);
    cnt_w = 0; cnt_g = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (vram_we) cnt_w++;
      if (disp_gnt) cnt_g++;
      tick();
    end
    chk("prio_no_cpu", cnt_w, 0);
    chk("prio_gnt", cnt_g, 5);
    disp_req = 1'b0;
    #1;
    chk("prio_issue_we", vram_we, 1);
    chk("prio_issue_addr", vram_addr, 14'h0C00);
    tick();
    chk("prio_mem", vram[14'h0C00], 8'h5A);

    // write then read-after-write, rvalid 3 cycles after the first push
    push_cmd(1'b1, 14'h1234, 8'hA5);
    push_cmd(1'b0, 14'h1234, 8'h00);
    chk("raw_early", cpu_rvalid, 0);
    tick();
    chk("raw_rvalid", cpu_rvalid, 1);
    chk("raw_rdata", cpu_rdata, 8'hA5);
    tick();
    chk("raw_pulse", cpu_rvalid, 0);
    chk("raw_hold", cpu_rdata, 8'hA5);

    // overflow: fifth push dropped while display hogs the port
    disp_req = 1'b1; disp_addr = 14'h0800;
    push_cmd(1'b1, 14'h2000, 8'h11);
    push_cmd(1'b1, 14'h2001, 8'h22);
    push_cmd(1'b0, 14'h2000, 8'h00);
    chk("ovf_not_full_3", cpu_full, 0);
    push_cmd(1'b0, 14'h2001, 8'h00);
    chk("ovf_full_4", cpu_full, 1);
    chk("ovf_clear_4", ovf, 0);
    push_cmd(1'b1, 14'h2002, 8'h33);
    chk("ovf_set", ovf, 1);
    chk("ovf_still_full", cpu_full, 1);
    disp_req = 1'b0;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (cpu_rvalid && got < 8) begin
        rd[got] = cpu_rdata;
        got++;
      end
      tick();
    end
    chk("ovf_reads", got, 2);
    chk("ovf_rd0", rd[0], 8'h11);
    chk("ovf_rd1", rd[1], 8'h22);
    chk("ovf_dropped", vram[14'h2002], 8'h00);

    // long display burst saturates the wait statistic
    disp_req = 1'b1;
    push_cmd(1'b0, 14'h0C00, 8'h00);
    repeat (300) tick();
    disp_req = 1'b0;
    tick(); tick();
    chk("wait_sat", wait_max, 255);
    chk("wait_rdata", cpu_rdata, 8'h5A);

    // reset while a read issues and three more are queued
    disp_req = 1'b1;
    for (int k = 0; k < 4; k++) push_cmd(1'b0, 14'h0C00, 8'h00);
    disp_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_addr", vram_addr, 0);
    chk("mid_rst_we", vram_we, 1);
    chk("mid_rst_busy", cpu_busy, 1);
    chk("mid_rst_full", cpu_full, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_wmax", wait_max, 0);
    cnt_w = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (cpu_rvalid) cnt_w++;
      tick();
    end
    chk("mid_rst_no_rvalid", cnt_w, 0);
    repeat (N - 5) tick();
    cnt_w = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (vram_we) cnt_w++;
      tick();
    end
    chk("mid_rst_flushed", cnt_w, 0);
    chk("mid_rst_idle", cpu_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vdp99_vram_arb.md
# vdp99_vram_arb

Single-port VRAM arbiter and sequencer for the vdp99 core. Shares the 16 KiB VRAM between the display fetch FSM (hard priority) and the CPU port (buffered through a small command FIFO). It also zero-fills VRAM after reset. It sits between `fsm`/CPU-port logic and `mem` inside the VDP, in the `pxclk` domain.

## Interface
- `ADDR_W`, 14: VRAM address width (16 KiB).
- `DEPTH`, 4: CPU command FIFO entries (power of two, ≥2).
- `CLEAR_ON_RESET`, 1: when 1, zero-fill VRAM after reset; when 0, go straight to RUN.

Ports:
- `pxclk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `disp_req` in 1: display fetch wants a VRAM read this cycle.
- `disp_addr` in ADDR_W: display read address.
- `disp_gnt` out 1: display read issued this cycle.
- `disp_valid` out 1: `disp_data` valid; occurs one cycle after `disp_gnt`.
- `disp_data` out 8: display read data.
- `cpu_push` in 1: enqueue one CPU command (single-cycle pulse, already synchronized).
- `cpu_we` in 1: command type; 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: command address.
- `cpu_wdata` in 8: write data.
- `cpu_full` out 1: FIFO full.
- `cpu_busy` out 1: FIFO non-empty, CPU access in flight, or INIT active.
- `cpu_rvalid` out 1: CPU read data valid (single-cycle pulse).
- `cpu_rdata` out 8: CPU read data; held until the next CPU read completes.
- `ovf` out 1: sticky; set when a push is dropped.
- `wait_max` out 8: saturating maximum number of cycles any FIFO head waited.
- `vram_addr` out ADDR_W, `vram_we` out 1, `vram_wdata` out 8: VRAM port.
- `vram_rdata` in 8: VRAM read data, one-cycle registered latency.

## Operation
- States:
  - INIT: walks addresses 0..2^ADDR_W−1, writing 0x00, one per cycle. On the last address it moves to RUN.
  - RUN: normal arbitration.
  - Reset enters INIT when `CLEAR_ON_RESET`=1, otherwise RUN.
- Behaviour in INIT:
  - `disp_gnt`=0; display requests are ignored, not queued.
  - `cpu_push` is still accepted into the FIFO; entries wait until RUN.
- Behaviour in RUN, priority per cycle:
  1. `disp_req`=1: `disp_gnt`=1, `vram_addr`=`disp_addr`, `vram_we`=0.
  2. Otherwise, FIFO non-empty: pop the head and drive its addr/we/wdata to VRAM. For a read, `cpu_rvalid` pulses one cycle later.
  3. Otherwise: idle, `vram_we`=0, `vram_addr` holds its last value.
- The display is never stalled. The CPU uses only cycles the display leaves free.
- FIFO push/pop rules:
  - Push when `cpu_full`=1 is dropped and sets `ovf`. Fullness is evaluated before any same-cycle pop.
  - Simultaneous push and pop on a non-full FIFO: both take effect; count is unchanged.
  - Commands complete in push order. A read after a write to the same address returns the new data.
- Wait counter:
  - Counts cycles while the FIFO is non-empty, in RUN, and the head is not popped. It saturates at 255.
  - On pop, `wait_max` = max(`wait_max`, count); the count then clears.
- Reset values:
  - All outputs 0, FIFO empty, `ovf`=0, `wait_max`=0, `cpu_rdata`=0x00.
  - `cpu_busy`=1 in INIT.
- Reset mid-operation: the FIFO is flushed and an in-flight read produces no `cpu_rvalid`. INIT restarts at address 0.

## Timing
- `disp_gnt` and the VRAM address/we/wdata mux are combinational from `disp_req`, state, and FIFO head (registered). There is no registered output on the request path.
- `disp_valid`/`disp_data` and `cpu_rvalid`/`cpu_rdata` are registered: exactly 1 cycle after issue. `disp_data` equals `vram_rdata` while `disp_valid`=1.
- CPU latency:
  - Push at cycle N: earliest issue is N+1, earliest `cpu_rvalid` is N+2.
  - Each cycle with `disp_req`=1 adds one cycle.
- `cpu_full` and `cpu_busy` are registered and reflect the state after the current cycle's push/pop.
- INIT lasts exactly 2^ADDR_W cycles after reset deasserts. The first RUN cycle is at cycle 2^ADDR_W.

## Structure
- `vdp99_pkg` holds:
  - `ADDR_W` default.
  - State encoding localparams (`ST_INIT`, `ST_RUN`).
  - Command word layout `{we, addr, wdata}` with width `CMD_W = 1+ADDR_W+8`.
- Sub-module `vdp99_cmd_fifo`: synchronous FIFO with `DEPTH` entries and `CMD_W` width. Ports: push, pop, full, empty, head data. Pointers are binary with an extra wrap bit.
- The arbiter FSM, wait counter, and read-return pipeline live in the top module.

## Test plan
- Reset with `CLEAR_ON_RESET`=1 and VRAM preloaded with 0xFF → 16384 writes of 0x00 at ascending addresses. `disp_gnt` stays 0 throughout. Every location reads 0x00 afterwards.
- RUN, `disp_req` held 1 with addr 0x0800, while pushing a CPU write of 0x5A to 0x0C00 → no CPU issue while `disp_req`=1. When `disp_req` drops, the write issues on the next cycle and 0x0C00=0x5A.
- Push write(0x1234, 0xA5) then read(0x1234) with `disp_req`=0 → `cpu_rvalid` pulses 3 cycles after the first push, `cpu_rdata`=0xA5.
- Push 5 commands back-to-back while `disp_req`=1 (`DEPTH`=4) → `cpu_full`=1 after the 4th, the 5th is dropped, `ovf`=1. Only 4 commands complete, in order.
- Hold `disp_req`=1 for 300 cycles with one queued read → `wait_max`=255 after the pop.
- Assert `reset` for one cycle with 3 queued reads and one in flight → no `cpu_rvalid`, FIFO empty, INIT restarts at address 0.
